// File: rtl/prog_loader.sv
// Program-memory loader: parses a SYNC/count/words/checksum byte stream from the UART
// and writes 18-bit instructions into the program RAM, holding the MCU in reset meanwhile.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 10,
  parameter int         DATA_W    = 18
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              MCU_RST,
  output logic              DONE,
  output logic              ERR,
  output logic [3:0]        DBG_STATE
);

  // Handshake: a byte moves only on a cycle where RX_VALID && RX_READY at the rising
  // edge; the sender holds RX_DATA/RX_VALID until then, and RX_READY never depends on RX_VALID.

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CNT_HI = 4'd1,
    S_CNT_LO = 4'd2,
    S_B0     = 4'd3,
    S_B1     = 4'd4,
    S_B2     = 4'd5,
    S_WRITE  = 4'd6,
    S_CHK    = 4'd7,
    S_FIN    = 4'd8
  } state_t;

  localparam logic [10:0] N_MAX = 11'(1 << ADDR_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt_hi;
  logic [10:0]         r_n;
  logic [10:0]         r_wcnt;
  logic [1:0]          r_b0;
  logic [7:0]          r_b1;
  logic [7:0]          r_sum;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_mcu_rst;
  logic                r_done;
  logic                r_err;

  logic                w_ready;
  logic                w_xfer;
  logic [10:0]         w_n;
  logic                w_n_ok;
  logic                w_last;
  logic                w_sync;
  logic                w_chk_ok;

  assign w_ready  = !RST && (r_state != S_WRITE) && (r_state != S_FIN);
  assign w_xfer   = RX_VALID && w_ready;
  assign w_n      = {r_cnt_hi, RX_DATA};
  assign w_n_ok   = (w_n != 11'd0) && (w_n <= N_MAX);
  assign w_last   = (r_wcnt + 11'd1) == r_n;
  assign w_sync   = w_xfer && (r_state == S_IDLE) && (RX_DATA == SYNC_BYTE);
  assign w_chk_ok = RX_DATA == r_sum;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_sync) w_state_nxt = S_CNT_HI;
      S_CNT_HI: if (w_xfer) w_state_nxt = S_CNT_LO;
      S_CNT_LO: if (w_xfer) w_state_nxt = w_n_ok ? S_B0 : S_IDLE;
      S_B0:     if (w_xfer) w_state_nxt = S_B1;
      S_B1:     if (w_xfer) w_state_nxt = S_B2;
      S_B2:     if (w_xfer) w_state_nxt = S_WRITE;
      S_WRITE:  w_state_nxt = w_last ? S_CHK : S_B0;
      S_CHK:    if (w_xfer) w_state_nxt = w_chk_ok ? S_FIN : S_IDLE;
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: count capture, word assembly, running checksum and status flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt_hi  <= '0;
      r_n       <= '0;
      r_wcnt    <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_sum     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_mcu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sync) begin
            r_mcu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wcnt    <= '0;
            r_sum     <= '0;
          end
        end
        S_CNT_HI: if (w_xfer) r_cnt_hi <= RX_DATA[2:0];
        S_CNT_LO: begin
          if (w_xfer) begin
            r_n <= w_n;
            if (!w_n_ok) r_err <= 1'b1;
          end
        end
        S_B0: begin
          if (w_xfer) begin
            r_b0  <= RX_DATA[1:0];
            r_sum <= r_sum + RX_DATA;
          end
        end
        S_B1: begin
          if (w_xfer) begin
            r_b1  <= RX_DATA;
            r_sum <= r_sum + RX_DATA;
          end
        end
        S_B2: begin
          // Address/data are latched here so they stay put after the write strobe.
          if (w_xfer) begin
            r_sum     <= r_sum + RX_DATA;
            r_wr_addr <= r_wcnt[ADDR_W-1:0];
            r_wr_data <= {r_b0, r_b1, RX_DATA};
          end
        end
        S_WRITE: r_wcnt <= r_wcnt + 11'd1;
        S_CHK:   if (w_xfer && !w_chk_ok) r_err <= 1'b1;
        S_FIN: begin
          r_done    <= 1'b1;
          r_mcu_rst <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to their reset values combinationally while RST is high
  always_comb begin
    RX_READY  = w_ready;
    WR_EN     = 1'b0;
    WR_ADDR   = '0;
    WR_DATA   = '0;
    MCU_RST   = 1'b1;
    DONE      = 1'b0;
    ERR       = 1'b0;
    DBG_STATE = r_state;
    if (!RST) begin
      WR_EN   = (r_state == S_WRITE);
      WR_ADDR = r_wr_addr;
      WR_DATA = r_wr_data;
      MCU_RST = r_mcu_rst;
      DONE    = r_done;
      ERR     = r_err;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built as byte arrays, the expected RAM writes and
// final flags are derived from the frame rules, and a monitor scores every write strobe.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        WR_EN;
  logic [9:0]  WR_ADDR;
  logic [17:0] WR_DATA;
  logic        MCU_RST;
  logic        DONE;
  logic        ERR;
  logic [3:0]  DBG_STATE;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [27:0] exp_q[$];
  logic [7:0]  frm_b [0:3071];
  int          wr_seen      = 0;
  int          last_wr_addr = -1;

  prog_loader dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .MCU_RST(MCU_RST),
    .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  // Scoreboard: every write strobe must match the oldest expected {addr, data}
  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      logic [27:0] exp;
      wr_seen++;
      last_wr_addr = int'(WR_ADDR);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got addr=%0d data=%05h, required no write", WR_ADDR, WR_DATA);
      end else begin
        exp = exp_q.pop_front();
        if ({WR_ADDR, WR_DATA} !== exp) begin
          tests_failed++;
          $display("FAIL write: got addr=%0d data=%05h, required addr=%0d data=%05h",
                   WR_ADDR, WR_DATA, exp[27:18], exp[17:0]);
        end
      end
    end
  end

  // Driver: offer one byte after a random gap, hold until accepted, sample the next cycle
  task automatic send_byte(input logic [7:0] b, input int max_gap, output logic rdy, output logic wr);
    int g;
    int k;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    k = 0;
    while (RX_READY !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 100) begin
      tests_run++;
      tests_failed++;
      $display("FAIL byte_accept_timeout: got RX_READY low for 100 cycles, required acceptance of %02h", b);
      RX_VALID = 1'b0;
      rdy = 1'bx;
      wr  = 1'bx;
    end else begin
      @(posedge CLK);
      #1;
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom);
      @(negedge CLK);
      rdy = RX_READY;
      wr  = WR_EN;
    end
  endtask

  // Sends SYNC, count, words from frm_b and checksum; queues the expected writes.
  // rdy_bad counts cycles after a handshake where RX_READY/WR_EN differ from the frame rules.
  // abort_words >= 0 stops right after that many complete words.
  task automatic send_frame(input logic [7:0] cnt_hi, input logic [7:0] cnt_lo, input int abort_words,
                            input bit bad_chk, input int max_gap, output int rdy_bad);
    int         n;
    logic [7:0] sum;
    logic [7:0] b0, b1, b2, chk;
    logic       rdy, wr;
    n       = int'({cnt_hi[2:0], cnt_lo});
    sum     = 8'h00;
    rdy_bad = 0;
    send_byte(8'hA5, max_gap, rdy, wr);
    if (rdy !== 1'b1) rdy_bad++;
    send_byte(cnt_hi, max_gap, rdy, wr);
    if (rdy !== 1'b1) rdy_bad++;
    send_byte(cnt_lo, max_gap, rdy, wr);
    if (rdy !== 1'b1) rdy_bad++;
    if (n < 1 || n > 1024) return;
    for (int i = 0; i < n; i++) begin
      if (abort_words >= 0 && i == abort_words) return;
      b0 = frm_b[3*i];
      b1 = frm_b[3*i+1];
      b2 = frm_b[3*i+2];
      sum = sum + b0 + b1 + b2;
      exp_q.push_back({10'(i), b0[1:0], b1, b2});
      send_byte(b0, max_gap, rdy, wr);
      if (rdy !== 1'b1 || wr !== 1'b0) rdy_bad++;
      send_byte(b1, max_gap, rdy, wr);
      if (rdy !== 1'b1 || wr !== 1'b0) rdy_bad++;
      send_byte(b2, max_gap, rdy, wr);
      if (rdy !== 1'b0 || wr !== 1'b1) rdy_bad++;
    end
    chk = bad_chk ? (sum ^ 8'h01) : sum;
    send_byte(chk, max_gap, rdy, wr);
    if (rdy !== (bad_chk ? 1'b1 : 1'b0)) rdy_bad++;
  endtask

  task automatic fill_random(input int n_words);
    for (int i = 0; i < 3 * n_words; i++) frm_b[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    RST      = 1'b1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    repeat (2) @(negedge CLK);
    tests_run += 7;
    if (MCU_RST !== 1'b1) begin tests_failed++; $display("FAIL reset_mcu_rst: got %b, required 1", MCU_RST); end
    if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, required 0", DONE); end
    if (ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b, required 0", ERR); end
    if (WR_EN !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b, required 0", WR_EN); end
    if (RX_READY !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_ready: got %b, required 0", RX_READY); end
    if (WR_ADDR !== 10'd0) begin tests_failed++; $display("FAIL reset_wr_addr: got %0d, required 0", WR_ADDR); end
    if (WR_DATA !== 18'd0) begin tests_failed++; $display("FAIL reset_wr_data: got %05h, required 0", WR_DATA); end
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    tests_run += 3;
    if (RX_READY !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready: got %b, required 1", RX_READY); end
    if (DBG_STATE !== 4'd0) begin tests_failed++; $display("FAIL post_reset_state: got %0d, required 0 (IDLE)", DBG_STATE); end
    if (MCU_RST !== 1'b1) begin tests_failed++; $display("FAIL post_reset_mcu_rst: got %b, required 1", MCU_RST); end
  endtask

  task automatic test_single_word();
    int rdy_bad;
    int w0;
    w0 = wr_seen;
    frm_b[0] = 8'h03; frm_b[1] = 8'h12; frm_b[2] = 8'h34;
    send_frame(8'h00, 8'h01, -1, 1'b0, 0, rdy_bad);
    repeat (2) @(negedge CLK);
    tests_run += 6;
    if (rdy_bad !== 0) begin tests_failed++; $display("FAIL single_ready: got %0d bad cycles, required 0", rdy_bad); end
    if (wr_seen - w0 !== 1) begin tests_failed++; $display("FAIL single_writes: got %0d, required 1", wr_seen - w0); end
    if (DONE !== 1'b1) begin tests_failed++; $display("FAIL single_done: got %b, required 1", DONE); end
    if (MCU_RST !== 1'b0) begin tests_failed++; $display("FAIL single_mcu_rst: got %b, required 0", MCU_RST); end
    if (ERR !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b, required 0", ERR); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_three_words_gaps();
    int rdy_bad;
    frm_b[0] = 8'hFF; frm_b[1] = 8'hFF; frm_b[2] = 8'hFF;
    frm_b[3] = 8'h00; frm_b[4] = 8'h00; frm_b[5] = 8'h01;
    frm_b[6] = 8'h02; frm_b[7] = 8'h00; frm_b[8] = 8'h00;
    send_frame(8'h00, 8'h03, -1, 1'b0, 4, rdy_bad);
    repeat (2) @(negedge CLK);
    tests_run += 4;
    if (rdy_bad !== 0) begin tests_failed++; $display("FAIL three_ready: got %0d bad cycles, required 0", rdy_bad); end
    if (DONE !== 1'b1) begin tests_failed++; $display("FAIL three_done: got %b, required 1", DONE); end
    if (last_wr_addr !== 2) begin tests_failed++; $display("FAIL three_last_addr: got %0d, required 2", last_wr_addr); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL three_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_bad_chk();
    int   rdy_bad;
    int   w0;
    logic rdy, wr;
    w0 = wr_seen;
    frm_b[0] = 8'h03; frm_b[1] = 8'h12; frm_b[2] = 8'h34;
    send_frame(8'h00, 8'h01, -1, 1'b1, 2, rdy_bad);
    repeat (2) @(negedge CLK);
    tests_run += 6;
    if (rdy_bad !== 0) begin tests_failed++; $display("FAIL badchk_ready: got %0d bad cycles, required 0", rdy_bad); end
    if (wr_seen - w0 !== 1) begin tests_failed++; $display("FAIL badchk_writes: got %0d, required 1", wr_seen - w0); end
    if (ERR !== 1'b1) begin tests_failed++; $display("FAIL badchk_err: got %b, required 1", ERR); end
    if (DONE !== 1'b0) begin tests_failed++; $display("FAIL badchk_done: got %b, required 0", DONE); end
    if (MCU_RST !== 1'b1) begin tests_failed++; $display("FAIL badchk_mcu_rst: got %b, required 1", MCU_RST); end
    if (DBG_STATE !== 4'd0) begin tests_failed++; $display("FAIL badchk_state: got %0d, required 0 (IDLE)", DBG_STATE); end
    send_byte(8'hA5, 0, rdy, wr);
    tests_run++;
    if (ERR !== 1'b0) begin tests_failed++; $display("FAIL sync_clears_err: got %b, required 0", ERR); end
    send_byte(8'h00, 0, rdy, wr);
    send_byte(8'h00, 0, rdy, wr);
  endtask

  task automatic test_illegal_count();
    int   rdy_bad;
    int   w0;
    logic rdy, wr;
    w0 = wr_seen;
    send_frame(8'h00, 8'h00, -1, 1'b0, 1, rdy_bad);
    @(negedge CLK);
    tests_run += 4;
    if (rdy_bad !== 0) begin tests_failed++; $display("FAIL n0_ready: got %0d bad cycles, required 0", rdy_bad); end
    if (ERR !== 1'b1) begin tests_failed++; $display("FAIL n0_err: got %b, required 1", ERR); end
    if (MCU_RST !== 1'b1) begin tests_failed++; $display("FAIL n0_mcu_rst: got %b, required 1", MCU_RST); end
    if (DBG_STATE !== 4'd0) begin tests_failed++; $display("FAIL n0_state: got %0d, required 0 (IDLE)", DBG_STATE); end
    send_byte(8'h55, 0, rdy, wr);
    tests_run += 2;
    if (ERR !== 1'b1) begin tests_failed++; $display("FAIL garbage_err: got %b, required 1 (kept)", ERR); end
    if (DBG_STATE !== 4'd0) begin tests_failed++; $display("FAIL garbage_state: got %0d, required 0 (IDLE)", DBG_STATE); end
    send_frame(8'h04, 8'h01, -1, 1'b0, 1, rdy_bad);
    @(negedge CLK);
    tests_run += 3;
    if (ERR !== 1'b1) begin tests_failed++; $display("FAIL n1025_err: got %b, required 1", ERR); end
    if (DONE !== 1'b0) begin tests_failed++; $display("FAIL n1025_done: got %b, required 0", DONE); end
    if (wr_seen !== w0) begin tests_failed++; $display("FAIL illegal_writes: got %0d, required 0", wr_seen - w0); end
  endtask

  task automatic test_random_frames();
    int rdy_bad;
    int n;
    bit bad;
    for (int f = 0; f < 6; f++) begin
      n   = int'($urandom_range(40, 1));
      bad = ($urandom_range(2, 0) == 0);
      fill_random(n);
      frm_b[$urandom_range(3 * n - 1, 0)] = 8'hA5;
      send_frame(8'(n >> 8), 8'(n), -1, bad, 3, rdy_bad);
      repeat (2) @(negedge CLK);
      tests_run += 5;
      if (rdy_bad !== 0) begin tests_failed++; $display("FAIL rand%0d_ready: got %0d bad cycles, required 0", f, rdy_bad); end
      if (DONE !== !bad) begin tests_failed++; $display("FAIL rand%0d_done: got %b, required %b", f, DONE, !bad); end
      if (ERR !== bad) begin tests_failed++; $display("FAIL rand%0d_err: got %b, required %b", f, ERR, bad); end
      if (MCU_RST !== bad) begin tests_failed++; $display("FAIL rand%0d_mcu_rst: got %b, required %b", f, MCU_RST, bad); end
      if (last_wr_addr !== n - 1) begin tests_failed++; $display("FAIL rand%0d_last_addr: got %0d, required %0d", f, last_wr_addr, n - 1); end
    end
  endtask

  task automatic test_full_image();
    int rdy_bad;
    int w0;
    w0 = wr_seen;
    fill_random(1024);
    send_frame(8'h04, 8'h00, -1, 1'b0, 0, rdy_bad);
    repeat (2) @(negedge CLK);
    tests_run += 5;
    if (rdy_bad !== 0) begin tests_failed++; $display("FAIL full_ready: got %0d bad cycles, required 0", rdy_bad); end
    if (wr_seen - w0 !== 1024) begin tests_failed++; $display("FAIL full_writes: got %0d, required 1024", wr_seen - w0); end
    if (last_wr_addr !== 1023) begin tests_failed++; $display("FAIL full_last_addr: got %0d, required 1023", last_wr_addr); end
    if (DONE !== 1'b1) begin tests_failed++; $display("FAIL full_done: got %b, required 1", DONE); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL full_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    int rdy_bad;
    int w0;
    fill_random(1024);
    send_frame(8'h04, 8'h00, 10, 1'b0, 1, rdy_bad);
    @(posedge CLK);
    #1 RST = 1'b1;
    w0 = wr_seen;
    repeat (2) @(negedge CLK);
    tests_run += 4;
    if (MCU_RST !== 1'b1) begin tests_failed++; $display("FAIL midrst_mcu_rst: got %b, required 1", MCU_RST); end
    if (DONE !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b, required 0", DONE); end
    if (WR_EN !== 1'b0) begin tests_failed++; $display("FAIL midrst_wr_en: got %b, required 0", WR_EN); end
    if (last_wr_addr !== 9) begin tests_failed++; $display("FAIL midrst_last_addr: got %0d, required 9", last_wr_addr); end
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) @(negedge CLK);
    tests_run++;
    if (wr_seen !== w0) begin tests_failed++; $display("FAIL midrst_writes_after: got %0d, required 0", wr_seen - w0); end
    fill_random(2);
    send_frame(8'h00, 8'h02, -1, 1'b0, 2, rdy_bad);
    repeat (2) @(negedge CLK);
    tests_run += 4;
    if (rdy_bad !== 0) begin tests_failed++; $display("FAIL reload_ready: got %0d bad cycles, required 0", rdy_bad); end
    if (DONE !== 1'b1) begin tests_failed++; $display("FAIL reload_done: got %b, required 1", DONE); end
    if (last_wr_addr !== 1) begin tests_failed++; $display("FAIL reload_last_addr: got %0d, required 1", last_wr_addr); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL reload_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_words_gaps();
    test_bad_chk();
    test_illegal_count();
    test_random_frames();
    test_full_image();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the RAT program memory: accepts a byte stream from the UART receiver and writes 18-bit instructions into the 1024x18 writable program RAM.
- The MCU fetch path reads the same RAM on its own port.
- Holds the MCU in reset while a load is in progress, and releases it only after a verified, complete image.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-image marker.
- ADDR_W, 10, program memory address width.
- DATA_W, 18, instruction width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  RX_DATA valid this cycle.
- RX_READY  out  1  loader accepts the byte; a transfer occurs when RX_VALID && RX_READY.
- WR_EN  out  1  program RAM write strobe, one cycle per word.
- WR_ADDR  out  10  program RAM write address.
- WR_DATA  out  18  program RAM write data.
- MCU_RST  out  1  hold MCU in reset.
- DONE  out  1  last load completed with good checksum.
- ERR  out  1  last load aborted (bad count or checksum).

Behaviour:
- Reset is synchronous and active-high on CLK. While RST is high, outputs are: RX_READY=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, MCU_RST=1, DONE=0, ERR=0. State returns to IDLE. An RST mid-load abandons the load; RAM contents already written stay.
- Frame format: SYNC, CNT_HI, CNT_LO, then N words of 3 bytes each (B0, B1, B2), then CHK.
- Word count: N = {CNT_HI[2:0], CNT_LO}, legal range 1..1024.
- Word assembly: word = {B0[1:0], B1, B2}. B0[7:2] are ignored.
- Checksum: CHK must equal the mod-256 sum of all word bytes (B0, B1, B2 of every word, all 8 bits).
- FSM states: IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CHK, FIN.
- RX_READY is 1 in every state except WRITE and FIN.
- IDLE:
  - A byte equal to SYNC_BYTE -> CNT_HI. On that transition: MCU_RST=1, DONE=0, ERR=0, address counter=0, checksum=0.
  - Any other byte is discarded. DONE, ERR and MCU_RST keep their current values.
- CNT_HI -> CNT_LO -> check N.
  - N==0 or N>1024: ERR=1, go to IDLE, MCU_RST stays 1.
  - Otherwise go to B0.
- B0 -> B1 -> B2. Each accepted byte is added to the checksum.
- Leaving B2 -> WRITE.
- WRITE (exactly one cycle):
  - WR_EN=1, WR_ADDR=current address, WR_DATA=assembled word.
  - The address counter then increments.
  - If words written == N, go to CHK; otherwise go to B0.
- WR_ADDR/WR_DATA hold their last values when WR_EN=0.
- Latency: the WR_EN pulse is asserted the cycle after the B2 handshake.
- CHK, accepted byte:
  - Match: go to FIN.
  - Mismatch: ERR=1, go to IDLE, MCU_RST stays 1.
- FIN (one cycle): DONE=1, MCU_RST=0, go to IDLE.
- DONE and ERR are sticky until the next SYNC is accepted or RST.
- Address wrap: N=1024 writes addresses 0..1023. The counter is never used past 1023.
- A SYNC_BYTE value received inside a frame is ordinary data, not a restart.
- Bytes are accepted only on RX_VALID && RX_READY. A stalled RX_VALID (gaps between bytes) is tolerated indefinitely; there is no timeout.
- Power-up: MCU_RST=1 until the first successful load.

Test Plan:
- Reset: RST high for 2 cycles -> MCU_RST=1, DONE=0, ERR=0, WR_EN=0, RX_READY=0; after release RX_READY=1, state IDLE.
- Single word: A5,00,01,03,12,34,49 -> one WR_EN pulse with WR_ADDR=0, WR_DATA=18'h31234; then DONE=1, MCU_RST=0, ERR=0.
- Three words with random RX_VALID gaps:
  - Stimulus: data 0x3FFFF, 0x00001, 0x20000.
  - Words/addresses: WR_EN pulses at addresses 0,1,2 with those data values.
  - Checksum bytes: B0/B1/B2 = FF,FF,FF; 00,00,01; 02,00,00.
  - Result: correct CHK 8'h00 -> DONE=1; RX_READY=0 only during WRITE and FIN cycles.
- Bad checksum: the single-word frame with CHK=48 -> one write occurs, then ERR=1, DONE=0, MCU_RST=1; next A5 clears ERR.
- Illegal count: A5,00,00 and separately A5,04,01 (N=1025) -> ERR=1, no WR_EN, back to IDLE; garbage byte 0x55 in IDLE ignored.
- Full image and reset mid-load:
  - N=1024 (04,00) -> last write WR_ADDR=1023, DONE=1.
  - Repeat with RST asserted after word 10 -> WR_EN stops, MCU_RST=1, DONE=0; a fresh frame then loads correctly starting at address 0.
